// File: rtl/rxrecclk_out_ctrl_if.sv
// rxrecclk_out_ctrl_if: request handshake between a requester and rxrecclk_out_ctrl
// req_valid/req_en/req_sel from requester, req_ready back from the controller
interface rxrecclk_out_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_en;
  logic [1:0] req_sel;
  modport master (output req_valid, req_en, req_sel, input req_ready);
  modport slave (input req_valid, req_en, req_sel, output req_ready);
endinterface

// File: rtl/rxrecclk_out_ctrl.sv
// rxrecclk_out_ctrl: glitch-free enable/select sequencing of a recovered-clock output buffer
// Ports: clk, reset_n (async, active-low), req (request handshake, slave side),
//   cdr_lock[3:0] per-channel lock, ceb (active-low buffer enable), rxrecclk_sel (mux select),
//   busy (QUIESCE/SETTLE), done (one-cycle completion pulse).
// Optional macro RECCLK_LOCK_GATE_EN: SETTLE also waits for cdr_lock of the selected channel,
//   and loss of lock while ON drops back to SETTLE.
module rxrecclk_out_ctrl #(
  parameter int QUIESCE_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rxrecclk_out_ctrl_if.slave   req,
  input  logic [3:0]           cdr_lock,
  output logic                 ceb,
  output logic [1:0]           rxrecclk_sel,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {OFF, QUIESCE, SETTLE, ON} state_t;
  localparam logic [7:0] Q_LAST = 8'(QUIESCE_CYCLES - 1);
  localparam logic [7:0] S_LAST = 8'(SETTLE_CYCLES - 1);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] pend_q, pend_d;
  logic       done_q, done_d;
  logic       ready, accept, lock_ok;
`ifdef RECCLK_LOCK_GATE_EN
  assign lock_ok = cdr_lock[sel_q];
`else
  logic unused_lock;
  assign unused_lock = ^cdr_lock;
  assign lock_ok = 1'b1;
`endif
  assign ready         = state_q == OFF || state_q == ON;
  assign req.req_ready = ready;
  assign accept        = req.req_valid && ready;
  assign ceb           = state_q != ON;
  assign busy          = !ready;
  assign done          = done_q;
  assign rxrecclk_sel  = sel_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
    sel_d   = sel_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      OFF: if (accept) begin
        cnt_d  = 8'd0;
        done_d = !req.req_en;
        if (req.req_en) begin
          sel_d   = req.req_sel;
          state_d = SETTLE;
        end
      end
      ON: if (!lock_ok) begin
        state_d = SETTLE;
        cnt_d   = 8'd0;
      end else if (accept) begin
        if (!req.req_en) begin
          state_d = OFF;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
        end else if (req.req_sel == sel_q) begin
          done_d = 1'b1;
        end else begin
          pend_d  = req.req_sel;
          state_d = QUIESCE;
          cnt_d   = 8'd0;
        end
      end
      QUIESCE: if (cnt_q == Q_LAST) begin
        sel_d   = pend_q;
        state_d = SETTLE;
        cnt_d   = 8'd0;
      end
      SETTLE: if (cnt_q >= S_LAST && lock_ok) begin
        state_d = ON;
        cnt_d   = 8'd0;
        done_d  = 1'b1;
      end
      default: state_d = OFF;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OFF;
      cnt_q   <= 8'd0;
      sel_q   <= 2'd0;
      pend_q  <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end
endmodule
